// File: rtl/tlb_trans_requester_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlb_req_pkg
// Description : Shared constants, records and helpers for the TLB
//               translation requester.
// Revision    : 1.0 - initial release
// ============================================================================
package tlb_req_pkg;

    localparam int unsigned c_ADDR_W  = 8;
    localparam int unsigned c_STATE_W = 2;

    localparam logic [c_STATE_W-1:0] c_IDLE = 2'd0;
    localparam logic [c_STATE_W-1:0] c_REQ  = 2'd1;
    localparam logic [c_STATE_W-1:0] c_GAP  = 2'd2;

    // Default-width records; the top re-declares them at its own ADDR_W.
    typedef struct packed {
        logic                spec;
        logic [c_ADDR_W-1:0] vaddr;
    } job_t;

    typedef struct packed {
        logic [c_ADDR_W-1:0] paddr;
        logic [c_ADDR_W-1:0] vaddr;
        logic                hit;
        logic                spec_hit;
        logic                err;
    } resp_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlb_trans_requester_fifo.sv
`default_nettype none
// ============================================================================
// Module      : trans_req_fifo
// Description : Synchronous job FIFO; pushes while full and pops while empty
//               are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module trans_req_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int unsigned      c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL  = (c_PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == c_FULL);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/tlb_trans_requester.sv
`default_nettype none
// ============================================================================
// Module      : tlb_trans_requester
// Description : Queues translation jobs and issues them to the speculative
//               TLB with a hold-until-done handshake, timeout and statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_trans_requester
    import tlb_req_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned ADDR_W     = c_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              JOB_VALID,
    output logic              JOB_READY,
    input  logic              JOB_SPEC,
    input  logic [ADDR_W-1:0] JOB_VADDR,
    output logic              TRANS_RQST,
    output logic              SPEC_TLB_RQST,
    output logic [ADDR_W-1:0] VIRT_ADDR_LOOKUP,
    input  logic              DONE_TRANS,
    input  logic              TLB_HIT,
    input  logic              SPEC_HIT,
    input  logic [ADDR_W-1:0] PHY_ADDR_TRANS,
    output logic              RESP_VALID,
    output logic [ADDR_W-1:0] RESP_PADDR,
    output logic [ADDR_W-1:0] RESP_VADDR,
    output logic              RESP_HIT,
    output logic              RESP_SPEC_HIT,
    output logic              RESP_ERR,
    input  logic              STAT_CLR,
    output logic [7:0]        HIT_CNT,
    output logic [7:0]        SPEC_CNT,
    output logic [7:0]        TMO_CNT
);

    localparam int unsigned         c_WAIT_W    = $clog2(TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

    typedef struct packed {
        logic              spec;
        logic [ADDR_W-1:0] vaddr;
    } job_rec_t;

    typedef struct packed {
        logic [ADDR_W-1:0] paddr;
        logic [ADDR_W-1:0] vaddr;
        logic              hit;
        logic              spec_hit;
        logic              err;
    } resp_rec_t;

    job_rec_t               w_push_job;
    job_rec_t               w_head_job;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic                   w_pop;
    logic                   w_in_req;
    logic                   w_hit_evt;
    logic                   w_spec_evt;
    logic                   w_tmo_evt;

    logic [c_STATE_W-1:0]   r_state;
    logic [c_WAIT_W-1:0]    r_wait;
    job_rec_t               r_hold;
    logic                   r_trans_rqst;
    logic                   r_resp_valid;
    resp_rec_t              r_resp;
    logic [7:0]             r_hit_cnt;
    logic [7:0]             r_spec_cnt;
    logic [7:0]             r_tmo_cnt;

    assign w_push_job.spec  = JOB_SPEC;
    assign w_push_job.vaddr = JOB_VADDR;
    assign w_pop            = (r_state == c_IDLE) && !w_fifo_empty;

    trans_req_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (ADDR_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (JOB_VALID),
        .i_data  (w_push_job),
        .i_pop   (w_pop),
        .o_data  (w_head_job),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Completion beats expiry when both land in the same cycle.
    assign w_in_req   = (r_state == c_REQ);
    assign w_hit_evt  = w_in_req && DONE_TRANS && TLB_HIT;
    assign w_spec_evt = w_in_req && DONE_TRANS && SPEC_HIT;
    assign w_tmo_evt  = w_in_req && !DONE_TRANS && (r_wait == c_WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_wait       <= '0;
            r_hold       <= '0;
            r_trans_rqst <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp       <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_hold       <= w_head_job;
                        r_wait       <= '0;
                        r_trans_rqst <= 1'b1;
                        r_state      <= c_REQ;
                    end
                end
                c_REQ: begin
                    r_wait <= r_wait + 1'b1;
                    if (DONE_TRANS) begin
                        r_resp.paddr    <= PHY_ADDR_TRANS;
                        r_resp.vaddr    <= r_hold.vaddr;
                        r_resp.hit      <= TLB_HIT;
                        r_resp.spec_hit <= SPEC_HIT;
                        r_resp.err      <= 1'b0;
                        r_resp_valid    <= 1'b1;
                        r_trans_rqst    <= 1'b0;
                        r_state         <= c_GAP;
                    end else if (r_wait == c_WAIT_LAST) begin
                        r_resp.paddr    <= '0;
                        r_resp.vaddr    <= r_hold.vaddr;
                        r_resp.hit      <= 1'b0;
                        r_resp.spec_hit <= 1'b0;
                        r_resp.err      <= 1'b1;
                        r_resp_valid    <= 1'b1;
                        r_trans_rqst    <= 1'b0;
                        r_state         <= c_GAP;
                    end
                end
                c_GAP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_trans_rqst <= 1'b0;
                    r_state      <= c_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || STAT_CLR) begin
            r_hit_cnt  <= '0;
            r_spec_cnt <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            if (w_hit_evt) begin
                r_hit_cnt <= sat_inc8(r_hit_cnt);
            end
            if (w_spec_evt) begin
                r_spec_cnt <= sat_inc8(r_spec_cnt);
            end
            if (w_tmo_evt) begin
                r_tmo_cnt <= sat_inc8(r_tmo_cnt);
            end
        end
    end

    assign JOB_READY        = !w_fifo_full;
    assign TRANS_RQST       = r_trans_rqst;
    assign SPEC_TLB_RQST    = r_trans_rqst && r_hold.spec;
    assign VIRT_ADDR_LOOKUP = r_hold.vaddr;
    assign RESP_VALID       = r_resp_valid;
    assign RESP_PADDR       = r_resp.paddr;
    assign RESP_VADDR       = r_resp.vaddr;
    assign RESP_HIT         = r_resp.hit;
    assign RESP_SPEC_HIT    = r_resp.spec_hit;
    assign RESP_ERR         = r_resp.err;
    assign HIT_CNT          = r_hit_cnt;
    assign SPEC_CNT         = r_spec_cnt;
    assign TMO_CNT          = r_tmo_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tlb_trans_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlb_trans_requester
// Description : Self-checking bench with a TLB responder model and a
//               response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlb_trans_requester;

    localparam int unsigned TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       JOB_VALID, JOB_READY, JOB_SPEC;
    logic [7:0] JOB_VADDR;
    logic       TRANS_RQST, SPEC_TLB_RQST;
    logic [7:0] VIRT_ADDR_LOOKUP;
    logic       DONE_TRANS, TLB_HIT, SPEC_HIT;
    logic [7:0] PHY_ADDR_TRANS;
    logic       RESP_VALID, RESP_HIT, RESP_SPEC_HIT, RESP_ERR;
    logic [7:0] RESP_PADDR, RESP_VADDR;
    logic       STAT_CLR;
    logic [7:0] HIT_CNT, SPEC_CNT, TMO_CNT;

    always #5 clk = ~clk;

    tlb_trans_requester #(
        .FIFO_DEPTH (4),
        .TIMEOUT    (TIMEOUT),
        .ADDR_W     (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .JOB_VALID        (JOB_VALID),
        .JOB_READY        (JOB_READY),
        .JOB_SPEC         (JOB_SPEC),
        .JOB_VADDR        (JOB_VADDR),
        .TRANS_RQST       (TRANS_RQST),
        .SPEC_TLB_RQST    (SPEC_TLB_RQST),
        .VIRT_ADDR_LOOKUP (VIRT_ADDR_LOOKUP),
        .DONE_TRANS       (DONE_TRANS),
        .TLB_HIT          (TLB_HIT),
        .SPEC_HIT         (SPEC_HIT),
        .PHY_ADDR_TRANS   (PHY_ADDR_TRANS),
        .RESP_VALID       (RESP_VALID),
        .RESP_PADDR       (RESP_PADDR),
        .RESP_VADDR       (RESP_VADDR),
        .RESP_HIT         (RESP_HIT),
        .RESP_SPEC_HIT    (RESP_SPEC_HIT),
        .RESP_ERR         (RESP_ERR),
        .STAT_CLR         (STAT_CLR),
        .HIT_CNT          (HIT_CNT),
        .SPEC_CNT         (SPEC_CNT),
        .TMO_CNT          (TMO_CNT)
    );

    // lat = cycle of the request on which DONE_TRANS is raised; 0 = never.
    typedef struct {
        logic       spec;
        logic [7:0] vaddr;
        int         lat;
        logic       late;
        logic [7:0] paddr;
        logic       hit;
        logic       sh;
    } tlb_rec_t;

    typedef struct packed {
        logic [7:0] paddr;
        logic [7:0] vaddr;
        logic       hit;
        logic       sh;
        logic       err;
    } exp_rec_t;

    typedef struct {
        tlb_rec_t stim;
        exp_rec_t exp;
    } vec_t;

    tlb_rec_t tlb_q[$];
    exp_rec_t exp_q[$];
    vec_t     vec[5];

    int   n_vec = 0, n_fail = 0;
    int   run_len = 0, last_run = 0, n_rise = 0;
    logic prev_rqst = 1'b0;
    int   e_hit = 0, e_spec = 0, e_tmo = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic exp_rec_t exp_ok(input tlb_rec_t t);
        return '{t.paddr, t.vaddr, t.hit, t.sh, 1'b0};
    endfunction

    function automatic int sat(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    // Scoreboard and request-edge monitor
    always @(negedge clk) begin
        if (TRANS_RQST) begin
            if (!prev_rqst) n_rise++;
            run_len++;
        end else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
        prev_rqst = TRANS_RQST;
        if (RESP_VALID) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_resp: got vaddr 0x%0h err %0b, expected no response",
                         RESP_VADDR, RESP_ERR);
            end else begin
                exp_rec_t e;
                e = exp_q.pop_front();
                chk("resp", {13'd0, RESP_PADDR, RESP_VADDR, RESP_HIT, RESP_SPEC_HIT, RESP_ERR},
                    {13'd0, e});
            end
        end
    end

    // TLB responder model
    initial begin
        tlb_rec_t t;
        DONE_TRANS = 1'b0; TLB_HIT = 1'b0; SPEC_HIT = 1'b0; PHY_ADDR_TRANS = 8'h00;
        forever begin
            @(negedge clk);
            if (TRANS_RQST) begin
                if (tlb_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_rqst: got vaddr 0x%0h, expected no request", VIRT_ADDR_LOOKUP);
                end else begin
                    t = tlb_q.pop_front();
                    chk("lookup", {23'd0, SPEC_TLB_RQST, VIRT_ADDR_LOOKUP}, {23'd0, t.spec, t.vaddr});
                    if (t.lat != 0) begin
                        repeat (t.lat - 1) @(negedge clk);
                        DONE_TRANS = 1'b1; PHY_ADDR_TRANS = t.paddr; TLB_HIT = t.hit; SPEC_HIT = t.sh;
                        @(negedge clk);
                        DONE_TRANS = 1'b0; TLB_HIT = 1'b0; SPEC_HIT = 1'b0;
                    end else begin
                        while (TRANS_RQST) @(negedge clk);
                        if (t.late) begin
                            DONE_TRANS = 1'b1; PHY_ADDR_TRANS = t.paddr; TLB_HIT = 1'b1; SPEC_HIT = 1'b1;
                            @(negedge clk);
                            DONE_TRANS = 1'b0; TLB_HIT = 1'b0; SPEC_HIT = 1'b0;
                        end
                    end
                end
                while (TRANS_RQST) @(negedge clk);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic push_job(input tlb_rec_t t, input exp_rec_t e, input bit has_resp);
        JOB_SPEC  = t.spec;
        JOB_VADDR = t.vaddr;
        JOB_VALID = 1'b1;
        if (has_resp) begin
            tlb_q.push_back(t);
            exp_q.push_back(e);
        end
        @(negedge clk);
        JOB_VALID = 1'b0;
    endtask

    task automatic wait_resp(input int budget, output int k);
        k = 0;
        while (!RESP_VALID && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!RESP_VALID) begin
            n_vec++;
            n_fail++;
            $display("FAIL resp_wait: got no response in %0d cycles, expected one", budget);
        end
    endtask

    task automatic chk_cnt(input string name);
        chk(name, {8'd0, HIT_CNT, SPEC_CNT, TMO_CNT}, {8'd0, e_hit[7:0], e_spec[7:0], e_tmo[7:0]});
    endtask

    initial begin
        tlb_rec_t t;
        int       k;
        int       rise0;

        rst = 1'b1; JOB_VALID = 1'b0; JOB_SPEC = 1'b0; JOB_VADDR = 8'h00; STAT_CLR = 1'b0;

        vec[0] = '{'{1'b1, 8'h3C,  2, 1'b0, 8'h9C, 1'b1, 1'b1}, '{8'h9C, 8'h3C, 1'b1, 1'b1, 1'b0}};
        vec[1] = '{'{1'b0, 8'hA5,  1, 1'b0, 8'h12, 1'b1, 1'b0}, '{8'h12, 8'hA5, 1'b1, 1'b0, 1'b0}};
        vec[2] = '{'{1'b1, 8'h7F,  5, 1'b0, 8'hFF, 1'b0, 1'b1}, '{8'hFF, 8'h7F, 1'b0, 1'b1, 1'b0}};
        vec[3] = '{'{1'b0, 8'h00,  3, 1'b0, 8'h00, 1'b0, 1'b0}, '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0}};
        vec[4] = '{'{1'b1, 8'hFE, 10, 1'b0, 8'h33, 1'b1, 1'b0}, '{8'h33, 8'hFE, 1'b1, 1'b0, 1'b0}};

        repeat (2) @(negedge clk);
        chk("reset_state", {1'b0, TRANS_RQST, SPEC_TLB_RQST, VIRT_ADDR_LOOKUP, RESP_VALID, RESP_PADDR,
                            RESP_VADDR, RESP_HIT, RESP_SPEC_HIT, RESP_ERR, JOB_READY}, 32'h1);
        chk_cnt("reset_cnt");
        rst = 1'b0;
        @(negedge clk);

        // Table: one job at a time, response latency = lat + 2 from push
        foreach (vec[i]) begin
            push_job(vec[i].stim, vec[i].exp, 1'b1);
            wait_resp(100, k);
            chk("latency", k, vec[i].stim.lat + 1);
            if (vec[i].exp.hit) e_hit = sat(e_hit);
            if (vec[i].exp.sh)  e_spec = sat(e_spec);
            chk_cnt("table_cnt");
        end
        @(negedge clk);

        // Back-to-back: a slow job keeps the FSM busy while the FIFO fills
        rise0 = n_rise;
        t = '{1'b0, 8'h00, 20, 1'b0, 8'h80, 1'b1, 1'b0};
        push_job(t, exp_ok(t), 1'b1);
        for (int i = 1; i <= 4; i++) begin
            t = '{1'b0, 8'(i), 1, 1'b0, 8'(8'h40 + i), 1'b1, 1'b0};
            push_job(t, exp_ok(t), 1'b1);
        end
        JOB_SPEC = 1'b1; JOB_VADDR = 8'h05; JOB_VALID = 1'b1;
        chk("ready_full", {31'd0, JOB_READY}, 32'd0);
        @(negedge clk);
        JOB_VALID = 1'b0;
        for (int r = 0; r < 5; r++) begin
            wait_resp(200, k);
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk("b2b_drained", exp_q.size(), 0);
        chk("b2b_rises", n_rise - rise0, 5);
        for (int r = 0; r < 5; r++) e_hit = sat(e_hit);
        chk_cnt("b2b_cnt");

        // Timeout with a late completion landing in GAP
        t = '{1'b0, 8'h55, 0, 1'b1, 8'hEE, 1'b1, 1'b1};
        push_job(t, '{8'h00, 8'h55, 1'b0, 1'b0, 1'b1}, 1'b1);
        wait_resp(200, k);
        chk("tmo_latency", k, TIMEOUT + 1);
        e_tmo = sat(e_tmo);
        chk_cnt("tmo_cnt");
        repeat (5) @(negedge clk);
        chk("tmo_run", last_run, TIMEOUT);
        chk_cnt("late_done_cnt");

        // Completion on the expiry cycle
        t = '{1'b1, 8'h66, TIMEOUT, 1'b0, 8'h77, 1'b1, 1'b0};
        push_job(t, exp_ok(t), 1'b1);
        wait_resp(200, k);
        chk("race_latency", k, TIMEOUT + 1);
        e_hit = sat(e_hit);
        chk_cnt("race_cnt");
        @(negedge clk);

        // Saturation
        for (int i = 0; i < 300; i++) begin
            t = '{1'b0, 8'(i), 1, 1'b0, 8'(i ^ 8'hA5), 1'b1, 1'b0};
            push_job(t, exp_ok(t), 1'b1);
            wait_resp(20, k);
            e_hit = sat(e_hit);
        end
        @(negedge clk);
        chk("hit_sat", {24'd0, HIT_CNT}, 32'd255);
        chk_cnt("sat_cnt");

        // Clear coincident with a hit
        t = '{1'b0, 8'hC1, 3, 1'b0, 8'h1C, 1'b1, 1'b1};
        push_job(t, exp_ok(t), 1'b1);
        repeat (t.lat) @(negedge clk);
        STAT_CLR = 1'b1;
        @(negedge clk);
        STAT_CLR = 1'b0;
        e_hit = 0; e_spec = 0; e_tmo = 0;
        chk("clr_resp_seen", {31'd0, RESP_VALID}, 32'd1);
        chk_cnt("clr_cnt");
        @(negedge clk);

        t = '{1'b0, 8'h21, 2, 1'b0, 8'h12, 1'b1, 1'b0};
        push_job(t, exp_ok(t), 1'b1);
        wait_resp(20, k);
        e_hit = sat(e_hit);
        chk_cnt("post_clr_cnt");
        @(negedge clk);

        // Reset during REQ with two jobs queued
        rise0 = n_rise;
        t = '{1'b1, 8'hA0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
        tlb_q.push_back(t);
        push_job(t, '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0}, 1'b0);
        k = 0;
        while (!TRANS_RQST && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("rst_req_up", {31'd0, TRANS_RQST}, 32'd1);
        t.vaddr = 8'hA1; push_job(t, '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0}, 1'b0);
        t.vaddr = 8'hA2; push_job(t, '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0}, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid", {5'd0, TRANS_RQST, RESP_VALID, JOB_READY, HIT_CNT, SPEC_CNT, TMO_CNT},
            {5'd0, 1'b0, 1'b0, 1'b1, 24'd0});
        repeat (80) @(negedge clk);
        chk("rst_no_req", n_rise - rise0, 1);
        chk("rst_tlb_q", tlb_q.size(), 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
